// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS test-signal generator.
package dds_pkg;

    localparam int DEF_GEN_WD   = 16;
    localparam int DEF_PHASE_WD = 24;
    localparam int DEF_LUT_AW   = 8;
    localparam int DEF_AMP_WD   = 8;

    typedef enum logic [1:0] {
        WM_SINE   = 2'd0,
        WM_SQUARE = 2'd1,
        WM_TRI    = 2'd2,
        WM_SAW    = 2'd3
    } wave_mode_e;

    // Pipeline-stage record at the default widths.
    typedef struct packed {
        logic                    valid;
        logic [DEF_PHASE_WD-1:0] phase;
        wave_mode_e              mode;
        logic [DEF_AMP_WD-1:0]   amp;
    } dds_stage_t;

endpackage

// File: rtl/dds_wave_gen_sine_qtr_rom.sv
// Quarter-wave sine table, filled at elaboration time; read combinationally.
module sine_qtr_rom #(
    parameter int LUT_AW = 8,
    parameter int GEN_WD = 16
) (
    input  logic [LUT_AW-1:0] addr_i,
    output logic [GEN_WD-1:0] data_o
);

    localparam int  N     = 2 ** LUT_AW;
    localparam real MAX_R = real'((2 ** (GEN_WD - 1)) - 1);

    // Entries are sampled at bin centres so the table never hits exactly 0.
    function automatic logic [GEN_WD-1:0] entry(input int k);
        real x;
        x = MAX_R * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N));
        return GEN_WD'($rtoi(x + 0.5));
    endfunction

    logic [GEN_WD-1:0] rom_s [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [GEN_WD-1:0] VAL = entry(k);
        assign rom_s[k] = VAL;
    end

    assign data_o = rom_s[addr_i];

endmodule

// File: rtl/dds_wave_gen.sv
// DDS test-signal source: phase accumulator, shape generation and saturating
// amplitude scaling, paced by a sample strobe with a registered valid pulse.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int GEN_WD   = DEF_GEN_WD,
    parameter int PHASE_WD = DEF_PHASE_WD,
    parameter int LUT_AW   = DEF_LUT_AW,
    parameter int AMP_WD   = DEF_AMP_WD
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                tick_i,
    input  logic                sync_i,
    input  logic [1:0]          mode_i,
    input  logic [PHASE_WD-1:0] ftw_i,
    input  logic [AMP_WD-1:0]   amp_i,
    output logic [GEN_WD-1:0]   wave_o,
    output logic                valid_o
);

    localparam int PW    = LUT_AW + 2;
    localparam int KW    = (GEN_WD + 1 > PW) ? GEN_WD + 1 : PW;
    localparam int PRODW = GEN_WD + AMP_WD + 1;

    localparam logic signed [GEN_WD-1:0] MAX_S     = {1'b0, {(GEN_WD-1){1'b1}}};
    localparam logic signed [GEN_WD-1:0] MIN_S     = {1'b1, {(GEN_WD-1){1'b0}}};
    localparam logic signed [GEN_WD-1:0] NEG_MAX_S = {1'b1, {(GEN_WD-2){1'b0}}, 1'b1};
    localparam logic signed [PRODW-1:0]  MAX_P     = {{(AMP_WD+1){1'b0}}, MAX_S};
    localparam logic signed [PRODW-1:0]  MIN_P     = {{(AMP_WD+1){1'b1}}, MIN_S};

    // Only the phase bits that any shape looks at travel down the pipeline.
    typedef struct packed {
        logic              valid;
        logic [KW-1:0]     phase;
        wave_mode_e        mode;
        logic [AMP_WD-1:0] amp;
    } s1_t;

    typedef struct packed {
        logic                     valid;
        logic signed [GEN_WD-1:0] raw;
        logic [AMP_WD-1:0]        amp;
    } s2_t;

    logic [PHASE_WD-1:0] acc_q, acc_d;
    s1_t                 s1_q, s1_d;
    s2_t                 s2_q, s2_d;
    logic [GEN_WD-1:0]   wave_q, wave_d;
    logic                valid_q, valid_d;

    logic                     accept_s;
    logic [PHASE_WD-1:0]      ph_s;
    logic [PW-1:0]            p_s;
    logic [1:0]               quad_s;
    logic [LUT_AW-1:0]        idx_s;
    logic [LUT_AW-1:0]        rom_addr_s;
    logic [GEN_WD-1:0]        rom_data_s;
    logic [GEN_WD:0]          t_s;
    logic [GEN_WD-1:0]        u_s;
    logic signed [GEN_WD-1:0] sine_s, tri_s, saw_s, raw_s;
    logic signed [PRODW-1:0]  prod_s, shifted_s;
    logic signed [GEN_WD-1:0] sat_s;

    assign accept_s = tick_i & en_i;
    assign ph_s     = sync_i ? {PHASE_WD{1'b0}} : acc_q;

    // Stage 0: phase sampling, accumulator update and control capture.
    always_comb begin
        acc_d = ph_s;
        if (accept_s) begin
            acc_d = ph_s + ftw_i;
        end else begin
            acc_d = ph_s;
        end
        s1_d.valid = accept_s;
        s1_d.phase = ph_s[PHASE_WD-1 -: KW];
        s1_d.mode  = wave_mode_e'(mode_i);
        s1_d.amp   = amp_i;
    end

    assign p_s        = s1_q.phase[KW-1 -: PW];
    assign quad_s     = p_s[PW-1 -: 2];
    assign idx_s      = p_s[LUT_AW-1:0];
    assign rom_addr_s = quad_s[0] ? ~idx_s : idx_s;

    sine_qtr_rom #(
        .LUT_AW (LUT_AW),
        .GEN_WD (GEN_WD)
    ) u_rom (
        .addr_i (rom_addr_s),
        .data_o (rom_data_s)
    );

    // Stage 1: shape generation from the captured phase.
    always_comb begin
        sine_s = $signed(rom_data_s);
        if (quad_s[1]) begin
            sine_s = -$signed(rom_data_s);
        end else begin
            sine_s = $signed(rom_data_s);
        end
        t_s = s1_q.phase[KW-1 -: GEN_WD+1];
        u_s = t_s[GEN_WD-1:0];
        if (t_s[GEN_WD]) begin
            u_s = ~t_s[GEN_WD-1:0];
        end else begin
            u_s = t_s[GEN_WD-1:0];
        end
        tri_s = {~u_s[GEN_WD-1], u_s[GEN_WD-2:0]};
        saw_s = {~s1_q.phase[KW-1], s1_q.phase[KW-2 -: GEN_WD-1]};
        case (s1_q.mode)
            WM_SINE:   raw_s = sine_s;
            WM_SQUARE: raw_s = quad_s[1] ? NEG_MAX_S : MAX_S;
            WM_TRI:    raw_s = tri_s;
            WM_SAW:    raw_s = saw_s;
            default:   raw_s = {GEN_WD{1'b0}};
        endcase
        s2_d.valid = s1_q.valid;
        s2_d.raw   = raw_s;
        s2_d.amp   = s1_q.amp;
    end

    // Stage 2: Q1.x gain with floor shift, then clamp to the sample range.
    always_comb begin
        prod_s    = $signed(s2_q.raw) * $signed({1'b0, s2_q.amp});
        shifted_s = prod_s >>> (AMP_WD - 1);
        sat_s     = shifted_s[GEN_WD-1:0];
        if (shifted_s > MAX_P) begin
            sat_s = MAX_S;
        end else if (shifted_s < MIN_P) begin
            sat_s = MIN_S;
        end else begin
            sat_s = shifted_s[GEN_WD-1:0];
        end
        wave_d = wave_q;
        if (s2_q.valid) begin
            wave_d = sat_s;
        end else begin
            wave_d = wave_q;
        end
        valid_d = s2_q.valid;
    end

    // All pipeline state; reset drops any in-flight samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= {PHASE_WD{1'b0}};
            s1_q    <= '0;
            s2_q    <= '0;
            wave_q  <= {GEN_WD{1'b0}};
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            wave_q  <= wave_d;
            valid_q <= valid_d;
        end
    end

    assign wave_o  = wave_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen at default parameters.
module tb_dds_wave_gen;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en_i, tick_i, sync_i;
    logic [1:0]  mode_i;
    logic [23:0] ftw_i;
    logic [7:0]  amp_i;
    logic [15:0] wave_o;
    logic        valid_o;

    always #5 clk = ~clk;

    dds_wave_gen dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .tick_i  (tick_i),
        .sync_i  (sync_i),
        .mode_i  (mode_i),
        .ftw_i   (ftw_i),
        .amp_i   (amp_i),
        .wave_o  (wave_o),
        .valid_o (valid_o)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t        sb_q[$];
    int          obs_q[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] acc_m    = 24'd0;

    function automatic int rom_m(input int k);
        return $rtoi(32767.0 * $sin(3.141592653589793 * (k + 0.5) / 512.0) + 0.5);
    endfunction

    function automatic int raw_m(input logic [23:0] ph, input int mode);
        int q, idx, t, u;
        q   = ph[23:22];
        idx = ph[21:14];
        t   = ph[23:7];
        case (mode)
            0: begin
                case (q)
                    0:       return rom_m(idx);
                    1:       return rom_m(255 - idx);
                    2:       return -rom_m(idx);
                    default: return -rom_m(255 - idx);
                endcase
            end
            1: return (q < 2) ? 32767 : -32767;
            2: begin
                u = (t >= 65536) ? 131071 - t : t;
                return u - 32768;
            end
            default: return int'(ph >> 8) - 32768;
        endcase
    endfunction

    function automatic int scale_m(input int raw, input int amp);
        int v;
        v = (raw * amp) >>> 7;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (valid_o === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: valid_o=1 wave_o=%0d at cycle %0d, required no sample", $signed(wave_o), cyc);
            end else begin
                e = sb_q.pop_front();
                if (int'($signed(wave_o)) !== e.val) begin
                    n_fail++;
                    $display("FAIL sample: got %0d, required %0d (cycle %0d)", $signed(wave_o), e.val, cyc);
                end
                n_checks++;
                if (cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL latency: valid at cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
            obs_q.push_back(int'($signed(wave_o)));
        end
    end

    task automatic drive(input bit tick, input bit en, input bit sync, input int mode,
                         input logic [23:0] ftw, input int amp);
        logic [23:0] ph;
        exp_t        e;
        @(negedge clk);
        tick_i = tick;
        en_i   = en;
        sync_i = sync;
        mode_i = mode[1:0];
        ftw_i  = ftw;
        amp_i  = amp[7:0];
        ph = sync ? 24'd0 : acc_m;
        if (tick && en) begin
            e.val = scale_m(raw_m(ph, mode), amp);
            e.due = cyc + 3;
            sb_q.push_back(e);
            acc_m = ph + ftw;
        end else begin
            acc_m = ph;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        @(negedge clk);
        tick_i = 1'b0;
        sync_i = 1'b0;
        while (sb_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d samples outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i = 1'b0; tick_i = 1'b0; sync_i = 1'b0;
        mode_i = 2'd0; ftw_i = 24'd0; amp_i = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wave_o !== 16'd0) begin
            n_fail++; $display("FAIL reset_wave: got %0d, required 0", wave_o);
        end
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, required 0", valid_o);
        end
        rst_ni = 1'b1;
        acc_m  = 24'd0;
    endtask

    task automatic test_saw();
        int exp_v[5] = '{-32768, -32512, -32256, 32512, -32768};
        int idx_v[5] = '{0, 1, 2, 255, 256};
        obs_q.delete();
        for (int i = 0; i < 257; i++) drive(1, 1, 0, 3, 24'h010000, 128);
        drain();
        n_checks++;
        if (obs_q.size() != 257) begin
            n_fail++; $display("FAIL saw_count: got %0d, required 257", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (obs_q[idx_v[i]] !== exp_v[i]) begin
                    n_fail++; $display("FAIL saw[%0d]: got %0d, required %0d", idx_v[i], obs_q[idx_v[i]], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_shape(input int mode, input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        obs_q.delete();
        for (int i = 0; i < 8; i++) drive(1, 1, (i == 0), mode, 24'h400000, 128);
        drain();
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++; $display("FAIL shape%0d_count: got %0d, required 8", mode, obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_v[i % 4]) begin
                    n_fail++; $display("FAIL shape%0d[%0d]: got %0d, required %0d", mode, i, obs_q[i], exp_v[i % 4]);
                end
            end
        end
    endtask

    task automatic test_amplitude();
        int exp_v[8] = '{16383, 16383, -16384, -16384, 32767, 32767, -32768, -32768};
        obs_q.delete();
        for (int i = 0; i < 4; i++) drive(1, 1, (i == 0), 1, 24'h400000, 64);
        for (int i = 0; i < 4; i++) drive(1, 1, (i == 0), 1, 24'h400000, 255);
        drain();
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++; $display("FAIL amp_count: got %0d, required 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_v[i]) begin
                    n_fail++; $display("FAIL amp[%0d]: got %0d, required %0d", i, obs_q[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_sine();
        obs_q.delete();
        for (int i = 0; i < 128; i++) drive(1, 1, (i == 0), 0, 24'h020000, 128);
        drain();
        n_checks++;
        if (obs_q.size() != 128) begin
            n_fail++; $display("FAIL sine_count: got %0d, required 128", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== 101) begin
                n_fail++; $display("FAIL sine[0]: got %0d, required 101", obs_q[0]);
            end
            n_checks++;
            if (obs_q[32] !== 32767) begin
                n_fail++; $display("FAIL sine[32]: got %0d, required 32767", obs_q[32]);
            end
            for (int n = 0; n < 64; n++) begin
                n_checks++;
                if (obs_q[n + 64] !== -obs_q[n]) begin
                    n_fail++; $display("FAIL sine_sym[%0d]: got %0d, required %0d", n, obs_q[n + 64], -obs_q[n]);
                end
            end
        end
    endtask

    task automatic test_control();
        logic [15:0] hold_v;
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 3, 24'h010000, 128);
            repeat (3) drive(0, 1, 0, 3, 24'h010000, 128);
        end
        obs_q.delete();
        drive(1, 1, 1, 3, 24'h010000, 128);
        drain();
        n_checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== -32768) begin
            n_fail++; $display("FAIL sync_phase: got %0d samples, last required -32768", obs_q.size());
        end
        drive(1, 1, 0, 3, 24'h010000, 128);
        drain();
        hold_v = wave_o;
        for (int i = 0; i < 10; i++) drive(1, 0, (i == 5), 3, 24'h010000, 128);
        n_checks++;
        if (wave_o !== hold_v) begin
            n_fail++; $display("FAIL enable_hold: got %0d, required %0d", $signed(wave_o), $signed(hold_v));
        end
        obs_q.delete();
        drive(1, 1, 0, 3, 24'h010000, 128);
        drain();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== -32768) begin
            n_fail++; $display("FAIL sync_while_disabled: got %0d samples, required one at -32768", obs_q.size());
        end
        drive(1, 1, 0, 3, 24'h010000, 128);
        @(negedge clk);
        rst_ni = 1'b0;
        tick_i = 1'b0;
        sb_q.delete();
        acc_m = 24'd0;
        #1;
        n_checks++;
        if (wave_o !== 16'd0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset: wave_o=%0d valid_o=%b, required 0/0", wave_o, valid_o);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (wave_o !== 16'd0) begin
            n_fail++; $display("FAIL post_reset_wave: got %0d, required 0", wave_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_saw();
        test_shape(1, 32767, 32767, -32767, -32767);
        test_shape(2, -32768, 0, 32767, -1);
        test_amplitude();
        test_sine();
        test_control();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL leftover: %0d expected samples never appeared, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
